axi_compare_ctrl: RTL and testbench
===================================

Name: axi_compare_ctrl

Overview:
Controller placed upstream of axi_bus_compare in lockstep/redundant AXI setups. It duplicates the slave-side AW/W/AR streams onto lane A and lane B with lossless fork handshakes. Responses are returned from lane A only. It tracks outstanding transactions and, on a comparator mismatch, quiesces traffic, drains in-flight bursts, then halts and interrupts until software clears it.

Parameters:
MaxTxns, 8, max outstanding write bursts and max outstanding read bursts; new AW/AR stall when reached
CntWidth, 16, width of saturating mismatch counter
HaltOnMismatch, 1'b1, 1: mismatch triggers DRAIN/HALTED; 0: count and flag only
axi_req_t, logic, AXI request struct type
axi_rsp_t, logic, AXI response struct type

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
slv_req_i  in  axi_req_t  upstream request
slv_rsp_o  out  axi_rsp_t  upstream response (B/R from lane A)
a_req_o  out  axi_req_t  lane A request (to comparator a side)
a_rsp_i  in  axi_rsp_t  lane A response
b_req_o  out  axi_req_t  lane B request; r_ready/b_ready tied 1
b_rsp_i  in  axi_rsp_t  lane B response (only aw/w/ar_ready used)
mismatch_i  in  5  {r,ar,b,w,aw} mismatch flags from comparator
cmp_busy_i  in  1  comparator has pending compares
clear_i  in  1  software clear pulse
halt_o  out  1  controller in HALTED
irq_o  out  1  one-cycle pulse on entering HALTED
mismatch_status_o  out  5  sticky OR of mismatch_i
mismatch_cnt_o  out  CntWidth  saturating mismatch-cycle count
outst_wr_o  out  $clog2(MaxTxns+1)  outstanding write bursts
outst_rd_o  out  $clog2(MaxTxns+1)  outstanding read bursts

Behaviour:
- Reset (synchronous, rst_ni=0 at clk_i edge): state RUN; all counters, status, taken flags 0; halt_o=0, irq_o=0. Handshake outputs follow combinationally from cleared state.
- Fork (per AW, W, AR): lane valid = slv valid & gate & !taken[lane]. taken[lane] sets on a lane handshake while the upstream beat is not complete. Upstream ready = (a_ready|taken_a) & (b_ready|taken_b) & gate. Taken flags clear on the upstream handshake. Zero added latency. Payload passes through unchanged.
- Once either lane has accepted a beat, the gate stays forced open until the upstream beat completes; no partial fork is ever abandoned.
- Responses: slv_rsp_o B/R fields = a_rsp_i; lane A b_ready/r_ready = slv_req_i. Lane B responses are consumed unconditionally.
- Counters:
  - outst_wr: +1 on upstream AW handshake, -1 on upstream B handshake.
  - w_pend: +1 on AW handshake, -1 on W handshake with w_last.
  - outst_rd: +1 on AR handshake, -1 on R handshake with r_last.
  - Simultaneous inc/dec leaves the value unchanged.
  - AW gate closed when outst_wr==MaxTxns; AR gate closed when outst_rd==MaxTxns.
  - Underflow is impossible by protocol; assert on it.
- States:
  - RUN: all gates open subject to limits. Any mismatch_i bit with HaltOnMismatch=1 -> DRAIN next cycle. The mismatching beat completes normally.
  - DRAIN: AW/AR gates closed (except in-progress fork). W gate open only while w_pend>0. B/R flow. When outst_wr==0, outst_rd==0, w_pend==0 and !cmp_busy_i -> HALTED, with irq_o=1 for exactly that transition cycle.
  - HALTED: halt_o=1; AW/W/AR gates closed. clear_i -> RUN.
- Status/count:
  - mismatch_status_o |= mismatch_i every cycle.
  - mismatch_cnt_o +1 each cycle with |mismatch_i, saturating at all-ones.
  - clear_i (any state) zeroes status and count. If clear_i and a mismatch occur in the same cycle, the new mismatch is recorded (count=1, status=mismatch_i).
  - clear_i in RUN/DRAIN does not change state.
- A mismatch arriving in DRAIN/HALTED updates status/count only.

Decomposition:
- Package axi_compare_ctrl_pkg: state enum (RUN, DRAIN, HALTED); mismatch bit index constants (MmAw=0, MmW=1, MmB=2, MmAr=3, MmR=4).
- Sub-module axi_compare_ctrl_fork: 2-way valid/ready fork with gate_i and synchronous reset, instantiated three times (AW, W, AR).

Test Plan:
- Write 4-beat INCR burst, lane B ready delayed 3 cycles, no mismatch -> each beat appears once per lane; upstream aw_ready only after both lanes accept; B OKAY returned; outst_wr returns to 0; halt_o stays 0.
- Issue 8 AR bursts with R held off, MaxTxns=8 -> 9th AR sees ar_ready=0 and no lane valid; one R last frees a slot next cycle.
- Write burst len=3, pulse mismatch_i=5'b00010 after beat 1 -> state DRAIN; remaining 2 W beats pass; new AR blocked; after B and cmp_busy_i=0: irq_o high exactly 1 cycle, halt_o=1, status=5'b00010, cnt=1.
- In HALTED pulse clear_i -> next cycle halt_o=0, status=0, cnt=0; subsequent AW accepted.
- Hold mismatch_i=5'b10000 for 2^CntWidth+5 cycles with HaltOnMismatch=0 -> cnt saturates at 16'hFFFF; state remains RUN; clear_i with concurrent mismatch -> cnt=1.
- Assert rst_ni low mid-burst with lane A already taken -> next edge: taken flags, counters, status cleared; state RUN; halt_o=0, irq_o=0.

Source files
------------

// File: rtl/axi_compare_ctrl_pkg.sv
// Shared types for the lockstep AXI compare controller: FSM states, mismatch
// flag indices and a default AXI request/response struct pair.
package axi_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam int unsigned MmAw  = 0;
  localparam int unsigned MmW   = 1;
  localparam int unsigned MmB   = 2;
  localparam int unsigned MmAr  = 3;
  localparam int unsigned MmR   = 4;
  localparam int unsigned NumMm = 5;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } default_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } default_rsp_t;

endpackage

// File: rtl/axi_compare_ctrl_fork.sv
// Lossless 2-way valid/ready fork. A beat completes upstream once both lanes
// have accepted it, possibly in different cycles; a started fork is never cut.
module axi_compare_ctrl_fork (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic gate_i,
  input  logic valid_i,
  output logic ready_o,
  output logic a_valid_o,
  input  logic a_ready_i,
  output logic b_valid_o,
  input  logic b_ready_i
);

  logic taken_a_q;
  logic taken_b_q;
  logic gate;

  // Any lane already holding the beat keeps the fork open until it finishes.
  assign gate      = gate_i | taken_a_q | taken_b_q;
  assign a_valid_o = valid_i & gate & ~taken_a_q;
  assign b_valid_o = valid_i & gate & ~taken_b_q;
  assign ready_o   = (a_ready_i | taken_a_q) & (b_ready_i | taken_b_q) & gate;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      taken_a_q <= 1'b0;
      taken_b_q <= 1'b0;
    end else if (valid_i && ready_o) begin
      taken_a_q <= 1'b0;
      taken_b_q <= 1'b0;
    end else begin
      if (a_valid_o && a_ready_i) taken_a_q <= 1'b1;
      if (b_valid_o && b_ready_i) taken_b_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_compare_ctrl.sv
// Lockstep AXI front end: forks AW/W/AR to two lanes, returns lane A responses,
// tracks outstanding bursts and drains/halts on a comparator mismatch.
module axi_compare_ctrl
  import axi_compare_ctrl_pkg::*;
#(
  parameter int unsigned MaxTxns        = 8,
  parameter int unsigned CntWidth       = 16,
  parameter bit          HaltOnMismatch = 1'b1,
  parameter type         axi_req_t      = default_req_t,
  parameter type         axi_rsp_t      = default_rsp_t,
  localparam int unsigned OutW          = $clog2(MaxTxns + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_req_t            slv_req_i,
  output axi_rsp_t            slv_rsp_o,
  output axi_req_t            a_req_o,
  input  axi_rsp_t            a_rsp_i,
  output axi_req_t            b_req_o,
  input  axi_rsp_t            b_rsp_i,
  input  logic [NumMm-1:0]    mismatch_i,
  input  logic                cmp_busy_i,
  input  logic                clear_i,
  output logic                halt_o,
  output logic                irq_o,
  output logic [NumMm-1:0]    mismatch_status_o,
  output logic [CntWidth-1:0] mismatch_cnt_o,
  output logic [OutW-1:0]     outst_wr_o,
  output logic [OutW-1:0]     outst_rd_o,
  output ctrl_state_e         state_o
);

  localparam logic [OutW-1:0] MaxCnt = OutW'(MaxTxns);

  ctrl_state_e     state_q, state_d;
  logic [OutW-1:0] outst_wr_q, outst_rd_q, w_pend_q;
  logic            aw_gate, w_gate, ar_gate, drained;
  logic            aw_ready, w_ready, ar_ready;
  logic            aw_a_valid, aw_b_valid, w_a_valid, w_b_valid, ar_a_valid, ar_b_valid;
  logic            aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic            unused_b_rsp;

  axi_compare_ctrl_fork u_fork_aw (
    .clk_i, .rst_ni, .gate_i(aw_gate), .valid_i(slv_req_i.aw_valid), .ready_o(aw_ready),
    .a_valid_o(aw_a_valid), .a_ready_i(a_rsp_i.aw_ready),
    .b_valid_o(aw_b_valid), .b_ready_i(b_rsp_i.aw_ready)
  );

  axi_compare_ctrl_fork u_fork_w (
    .clk_i, .rst_ni, .gate_i(w_gate), .valid_i(slv_req_i.w_valid), .ready_o(w_ready),
    .a_valid_o(w_a_valid), .a_ready_i(a_rsp_i.w_ready),
    .b_valid_o(w_b_valid), .b_ready_i(b_rsp_i.w_ready)
  );

  axi_compare_ctrl_fork u_fork_ar (
    .clk_i, .rst_ni, .gate_i(ar_gate), .valid_i(slv_req_i.ar_valid), .ready_o(ar_ready),
    .a_valid_o(ar_a_valid), .a_ready_i(a_rsp_i.ar_ready),
    .b_valid_o(ar_b_valid), .b_ready_i(b_rsp_i.ar_ready)
  );

  // Lane B responses are swallowed; only its request-side readies matter.
  assign unused_b_rsp = ^{b_rsp_i.b_valid, b_rsp_i.b, b_rsp_i.r_valid, b_rsp_i.r};

  always_comb begin
    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = aw_ready;
    slv_rsp_o.w_ready  = w_ready;
    slv_rsp_o.ar_ready = ar_ready;
    slv_rsp_o.b_valid  = a_rsp_i.b_valid;
    slv_rsp_o.b        = a_rsp_i.b;
    slv_rsp_o.r_valid  = a_rsp_i.r_valid;
    slv_rsp_o.r        = a_rsp_i.r;
    a_req_o            = slv_req_i;
    a_req_o.aw_valid   = aw_a_valid;
    a_req_o.w_valid    = w_a_valid;
    a_req_o.ar_valid   = ar_a_valid;
    b_req_o            = slv_req_i;
    b_req_o.aw_valid   = aw_b_valid;
    b_req_o.w_valid    = w_b_valid;
    b_req_o.ar_valid   = ar_b_valid;
    b_req_o.b_ready    = 1'b1;
    b_req_o.r_ready    = 1'b1;
  end

  assign aw_hs     = slv_req_i.aw_valid & aw_ready;
  assign w_last_hs = slv_req_i.w_valid & w_ready & slv_req_i.w.last;
  assign b_hs      = slv_req_i.b_ready & a_rsp_i.b_valid;
  assign ar_hs     = slv_req_i.ar_valid & ar_ready;
  assign r_last_hs = slv_req_i.r_ready & a_rsp_i.r_valid & a_rsp_i.r.last;
  assign drained   = (outst_wr_q == '0) && (outst_rd_q == '0) && (w_pend_q == '0) && !cmp_busy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (HaltOnMismatch && (|mismatch_i)) state_d = DRAIN;
      DRAIN:   if (drained) state_d = HALTED;
      HALTED:  if (clear_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    aw_gate = 1'b0;
    w_gate  = 1'b0;
    ar_gate = 1'b0;
    halt_o  = 1'b0;
    irq_o   = 1'b0;
    unique case (state_q)
      RUN: begin
        aw_gate = (outst_wr_q != MaxCnt);
        w_gate  = 1'b1;
        ar_gate = (outst_rd_q != MaxCnt);
      end
      DRAIN: begin
        w_gate = (w_pend_q != '0);
        irq_o  = drained;
      end
      HALTED:  halt_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_wr_q <= '0;
      outst_rd_q <= '0;
      w_pend_q   <= '0;
    end else begin
      if (aw_hs && !b_hs) outst_wr_q <= outst_wr_q + 1'b1;
      else if (b_hs && !aw_hs) outst_wr_q <= outst_wr_q - 1'b1;
      if (aw_hs && !w_last_hs) w_pend_q <= w_pend_q + 1'b1;
      else if (w_last_hs && !aw_hs) w_pend_q <= w_pend_q - 1'b1;
      if (ar_hs && !r_last_hs) outst_rd_q <= outst_rd_q + 1'b1;
      else if (r_last_hs && !ar_hs) outst_rd_q <= outst_rd_q - 1'b1;
    end
  end

  // A clear in the same cycle as a mismatch keeps the new event.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mismatch_status_o <= '0;
      mismatch_cnt_o    <= '0;
    end else if (clear_i) begin
      mismatch_status_o <= mismatch_i;
      mismatch_cnt_o    <= {{(CntWidth - 1){1'b0}}, |mismatch_i};
    end else begin
      mismatch_status_o <= mismatch_status_o | mismatch_i;
      if ((|mismatch_i) && (mismatch_cnt_o != '1)) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(b_hs && !aw_hs && outst_wr_q == '0));
      assert (!(w_last_hs && !aw_hs && w_pend_q == '0));
      assert (!(r_last_hs && !ar_hs && outst_rd_q == '0));
    end
  end

  assign outst_wr_o = outst_wr_q;
  assign outst_rd_o = outst_rd_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_axi_compare_ctrl.sv
// Directed bench for axi_compare_ctrl: fork handshakes, outstanding limits,
// mismatch drain/halt/clear, counter saturation and mid-burst reset.
module tb_axi_compare_ctrl;
  import axi_compare_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  default_req_t slv_req, a_req, b_req;
  default_rsp_t slv_rsp, a_rsp, b_rsp;
  logic [4:0]   mismatch;
  logic         cmp_busy, clear;
  logic         halt, irq;
  logic [4:0]   status;
  logic [15:0]  cnt;
  logic [3:0]   outst_wr, outst_rd;
  ctrl_state_e  state;

  default_req_t slv_req2, a_req2, b_req2;
  default_rsp_t slv_rsp2, a_rsp2, b_rsp2;
  logic [4:0]   mismatch2;
  logic         clear2, halt2, irq2;
  logic [4:0]   status2;
  logic [15:0]  cnt2;
  logic [3:0]   outst_wr2, outst_rd2;
  ctrl_state_e  state2;

  int tests = 0;
  int fails = 0;
  int a_aw_n = 0, b_aw_n = 0, a_w_n = 0, b_w_n = 0;

  always #5 clk = ~clk;

  axi_compare_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .a_req_o(a_req), .a_rsp_i(a_rsp), .b_req_o(b_req), .b_rsp_i(b_rsp),
    .mismatch_i(mismatch), .cmp_busy_i(cmp_busy), .clear_i(clear),
    .halt_o(halt), .irq_o(irq), .mismatch_status_o(status), .mismatch_cnt_o(cnt),
    .outst_wr_o(outst_wr), .outst_rd_o(outst_rd), .state_o(state)
  );

  axi_compare_ctrl #(.HaltOnMismatch(1'b0)) dut_nohalt (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req2), .slv_rsp_o(slv_rsp2),
    .a_req_o(a_req2), .a_rsp_i(a_rsp2), .b_req_o(b_req2), .b_rsp_i(b_rsp2),
    .mismatch_i(mismatch2), .cmp_busy_i(1'b0), .clear_i(clear2),
    .halt_o(halt2), .irq_o(irq2), .mismatch_status_o(status2), .mismatch_cnt_o(cnt2),
    .outst_wr_o(outst_wr2), .outst_rd_o(outst_rd2), .state_o(state2)
  );

  // Lane handshake monitor for the fork-duplication check
  always @(posedge clk) begin
    if (rst_n) begin
      if (a_req.aw_valid && a_rsp.aw_ready) a_aw_n = a_aw_n + 1;
      if (b_req.aw_valid && b_rsp.aw_ready) b_aw_n = b_aw_n + 1;
      if (a_req.w_valid && a_rsp.w_ready) a_w_n = a_w_n + 1;
      if (b_req.w_valid && b_rsp.w_ready) b_w_n = b_w_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; slv_req = '0; a_rsp = '0; b_rsp = '0;
    mismatch = '0; cmp_busy = 1'b0; clear = 1'b0;
    slv_req2 = '0; a_rsp2 = '0; b_rsp2 = '0; mismatch2 = '0; clear2 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    a_rsp.aw_ready = 1'b1; a_rsp.w_ready = 1'b1; a_rsp.ar_ready = 1'b1;
    b_rsp.w_ready = 1'b1; b_rsp.ar_ready = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'(RUN));
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_outst_wr", 32'(outst_wr), 32'd0);
    chk("rst_outst_rd", 32'(outst_rd), 32'd0);
    chk("rst_ar_ready", 32'(slv_rsp.ar_ready), 32'd1);

    // Write burst of 4 beats, lane B AW ready three cycles late
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h100; slv_req.aw.len = 8'd3; slv_req.aw.id = 4'd1;
    #1;
    chk("t1_a_awv0", 32'(a_req.aw_valid), 32'd1);
    chk("t1_b_awv0", 32'(b_req.aw_valid), 32'd1);
    chk("t1_awr0", 32'(slv_rsp.aw_ready), 32'd0);
    tick();
    chk("t1_a_awv1", 32'(a_req.aw_valid), 32'd0);
    chk("t1_awr1", 32'(slv_rsp.aw_ready), 32'd0);
    tick();
    chk("t1_awr2", 32'(slv_rsp.aw_ready), 32'd0);
    tick();
    b_rsp.aw_ready = 1'b1;
    #1;
    chk("t1_awr3", 32'(slv_rsp.aw_ready), 32'd1);
    chk("t1_b_awv3", 32'(b_req.aw_valid), 32'd1);
    chk("t1_b_addr", 32'(b_req.aw.addr), 32'h100);
    chk("t1_b_len", 32'(b_req.aw.len), 32'd3);
    tick();
    slv_req.aw_valid = 1'b0;
    chk("t1_outst_wr1", 32'(outst_wr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hA0 + i; slv_req.w.last = (i == 3);
      #1;
      chk("t1_wr", 32'(slv_rsp.w_ready), 32'd1);
      chk("t1_a_wdata", a_req.w.data, 32'hA0 + i);
      chk("t1_b_wdata", b_req.w.data, 32'hA0 + i);
      tick();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    a_rsp.b_valid = 1'b1; a_rsp.b.resp = 2'b00; a_rsp.b.id = 4'd1; slv_req.b_ready = 1'b1;
    #1;
    chk("t1_bvalid", 32'(slv_rsp.b_valid), 32'd1);
    chk("t1_bresp", 32'(slv_rsp.b.resp), 32'd0);
    chk("t1_bid", 32'(slv_rsp.b.id), 32'd1);
    chk("t1_a_bready", 32'(a_req.b_ready), 32'd1);
    chk("t1_b_bready", 32'(b_req.b_ready), 32'd1);
    tick();
    a_rsp.b_valid = 1'b0;
    chk("t1_outst_wr0", 32'(outst_wr), 32'd0);
    chk("t1_halt", 32'(halt), 32'd0);
    chk("t1_a_aw_n", a_aw_n, 32'd1);
    chk("t1_b_aw_n", b_aw_n, 32'd1);
    chk("t1_a_w_n", a_w_n, 32'd4);
    chk("t1_b_w_n", b_w_n, 32'd4);

    // Eight reads with R held off fill the read budget
    slv_req.r_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'(i * 64);
      #1;
      chk("t2_arr", 32'(slv_rsp.ar_ready), 32'd1);
      tick();
    end
    chk("t2_outst_rd8", 32'(outst_rd), 32'd8);
    chk("t2_arr_full", 32'(slv_rsp.ar_ready), 32'd0);
    chk("t2_a_arv_full", 32'(a_req.ar_valid), 32'd0);
    chk("t2_b_arv_full", 32'(b_req.ar_valid), 32'd0);
    a_rsp.r_valid = 1'b1; a_rsp.r.last = 1'b1; a_rsp.r.data = 32'h5A5A;
    #1;
    chk("t2_rvalid", 32'(slv_rsp.r_valid), 32'd1);
    chk("t2_rdata", slv_rsp.r.data, 32'h5A5A);
    chk("t2_b_rready", 32'(b_req.r_ready), 32'd1);
    chk("t2_arr_same", 32'(slv_rsp.ar_ready), 32'd0);
    tick();
    a_rsp.r_valid = 1'b0;
    chk("t2_outst_rd7", 32'(outst_rd), 32'd7);
    chk("t2_arr_free", 32'(slv_rsp.ar_ready), 32'd1);
    tick();
    slv_req.ar_valid = 1'b0;
    chk("t2_outst_rd8b", 32'(outst_rd), 32'd8);
    a_rsp.r_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    a_rsp.r_valid = 1'b0;
    chk("t2_outst_rd0", 32'(outst_rd), 32'd0);

    // Mismatch mid-burst: drain remaining beats, then halt with a single irq
    slv_req.aw_valid = 1'b1; slv_req.aw.len = 8'd3; slv_req.aw.id = 4'd3;
    tick();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hB0 + i; slv_req.w.last = 1'b0;
      tick();
    end
    slv_req.w_valid = 1'b0;
    mismatch = 5'b00010; cmp_busy = 1'b1;
    #1;
    chk("t3_state_run", 32'(state), 32'(RUN));
    tick();
    mismatch = '0;
    chk("t3_state_drain", 32'(state), 32'(DRAIN));
    chk("t3_halt_drain", 32'(halt), 32'd0);
    slv_req.ar_valid = 1'b1;
    #1;
    chk("t3_arr_blocked", 32'(slv_rsp.ar_ready), 32'd0);
    chk("t3_a_arv_blocked", 32'(a_req.ar_valid), 32'd0);
    for (int i = 2; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = 32'hB0 + i; slv_req.w.last = (i == 3);
      #1;
      chk("t3_wr_drain", 32'(slv_rsp.w_ready), 32'd1);
      chk("t3_b_wv_drain", 32'(b_req.w_valid), 32'd1);
      tick();
    end
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0;
    #1;
    chk("t3_wr_closed", 32'(slv_rsp.w_ready), 32'd0);
    chk("t3_a_wv_closed", 32'(a_req.w_valid), 32'd0);
    slv_req.w_valid = 1'b0;
    a_rsp.b_valid = 1'b1;
    tick();
    a_rsp.b_valid = 1'b0;
    chk("t3_outst_wr0", 32'(outst_wr), 32'd0);
    chk("t3_irq_busy", 32'(irq), 32'd0);
    chk("t3_state_busy", 32'(state), 32'(DRAIN));
    cmp_busy = 1'b0;
    #1;
    chk("t3_irq_edge", 32'(irq), 32'd1);
    tick();
    chk("t3_irq_after", 32'(irq), 32'd0);
    chk("t3_halt", 32'(halt), 32'd1);
    chk("t3_state_halted", 32'(state), 32'(HALTED));
    chk("t3_status", 32'(status), 32'h02);
    chk("t3_cnt", 32'(cnt), 32'd1);
    chk("t3_arr_halted", 32'(slv_rsp.ar_ready), 32'd0);
    tick();
    chk("t3_irq_later", 32'(irq), 32'd0);

    // Software clear returns to RUN and re-opens AW
    slv_req.ar_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("t4_halt_pre", 32'(halt), 32'd1);
    tick();
    clear = 1'b0;
    chk("t4_halt", 32'(halt), 32'd0);
    chk("t4_state", 32'(state), 32'(RUN));
    chk("t4_status", 32'(status), 32'd0);
    chk("t4_cnt", 32'(cnt), 32'd0);
    slv_req.aw_valid = 1'b1; slv_req.aw.len = 8'd0;
    #1;
    chk("t4_awr", 32'(slv_rsp.aw_ready), 32'd1);
    tick();
    slv_req.aw_valid = 1'b0;
    chk("t4_outst_wr1", 32'(outst_wr), 32'd1);
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    tick();
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    a_rsp.b_valid = 1'b1;
    tick();
    a_rsp.b_valid = 1'b0;
    chk("t4_outst_wr0", 32'(outst_wr), 32'd0);

    // Count-only instance: saturation and clear with a concurrent mismatch
    mismatch2 = 5'b10000;
    tick(); tick(); tick();
    chk("t5_cnt3", 32'(cnt2), 32'd3);
    for (int i = 3; i < 65541; i++) tick();
    chk("t5_cnt_sat", 32'(cnt2), 32'hFFFF);
    chk("t5_status", 32'(status2), 32'h10);
    chk("t5_state", 32'(state2), 32'(RUN));
    chk("t5_halt", 32'(halt2), 32'd0);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("t5_cnt_clr", 32'(cnt2), 32'd1);
    chk("t5_status_clr", 32'(status2), 32'h10);
    mismatch2 = '0;

    // Reset mid-fork with lane A already holding the AW beat
    b_rsp.aw_ready = 1'b0;
    slv_req.aw_valid = 1'b1; mismatch = 5'b00001;
    tick();
    mismatch = '0;
    chk("t6_a_awv_taken", 32'(a_req.aw_valid), 32'd0);
    chk("t6_b_awv_forced", 32'(b_req.aw_valid), 32'd1);
    chk("t6_state_drain", 32'(state), 32'(DRAIN));
    chk("t6_status_pre", 32'(status), 32'h01);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_state", 32'(state), 32'(RUN));
    chk("t6_status", 32'(status), 32'd0);
    chk("t6_cnt", 32'(cnt), 32'd0);
    chk("t6_outst_wr", 32'(outst_wr), 32'd0);
    chk("t6_halt", 32'(halt), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_a_awv_cleared", 32'(a_req.aw_valid), 32'd1);
    slv_req.aw_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
